// File: rtl/prv32_divider.sv
// prv32_divider: iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit is produced per clock. Divide-by-zero and signed overflow
// bypass the iteration and complete one edge after acceptance. Operands are
// taken on a valid/ready handshake and the result is returned on a second
// valid/ready handshake.
module prv32_divider #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result
);

   localparam int               CW        = $clog2(WIDTH);
   localparam logic [CW-1:0]    CNT_LAST  = CW'(WIDTH - 1);
   localparam logic [CW-1:0]    CNT_ZERO  = {CW{1'b0}};
   localparam logic [CW-1:0]    CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] ALL_ZERO  = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ALL_ONES  = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DIVIDE = 2'd1,
      S_FIX    = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   // Magnitude of an operand; the most negative value maps to the unsigned
   // value 2^(WIDTH-1), which is exactly what the two's complement gives.
   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                  input logic             is_signed);
      logic [WIDTH-1:0] m;
      if (is_signed && x[WIDTH-1]) begin
         m = ALL_ZERO - x;
      end else begin
         m = x;
      end
      return m;
   endfunction

   // Conditional two's complement negation used in the sign fix-up step.
   function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] x,
                                                   input logic             neg);
      logic [WIDTH-1:0] v;
      if (neg) begin
         v = ALL_ZERO - x;
      end else begin
         v = x;
      end
      return v;
   endfunction

   state_t             state_r;
   state_t             state_s;
   logic               in_ready_r;
   logic               in_ready_s;
   logic               out_valid_r;
   logic               out_valid_s;

   logic               is_rem_r;
   logic               neg_quo_r;
   logic               neg_rem_r;
   logic [WIDTH-1:0]   dvsr_r;
   logic [WIDTH-1:0]   quo_r;
   logic [WIDTH:0]     rem_r;
   logic [CW-1:0]      cnt_r;
   logic [WIDTH-1:0]   result_r;

   logic               accept_s;
   logic               is_signed_s;
   logic               div_zero_s;
   logic               overflow_s;
   logic               special_s;
   logic [WIDTH-1:0]   special_res_s;
   logic [WIDTH+1:0]   shifted_s;
   logic [WIDTH+1:0]   diff_s;
   logic               step_ok_s;
   logic [WIDTH:0]     rem_next_s;
   logic [WIDTH-1:0]   quo_next_s;
   logic [WIDTH-1:0]   fix_res_s;

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign result    = result_r;

   // Operand decode: acceptance, special-case detection and their results.
   always_comb begin
      accept_s      = in_valid & in_ready_r & ~flush;
      is_signed_s   = ~op[0];
      div_zero_s    = (b == ALL_ZERO);
      overflow_s    = is_signed_s & (a == MOST_NEG) & (b == ALL_ONES);
      special_s     = div_zero_s | overflow_s;
      special_res_s = ALL_ZERO;
      if (div_zero_s) begin
         if (op[1]) begin
            special_res_s = a;
         end else begin
            special_res_s = ALL_ONES;
         end
      end else begin
         if (op[1]) begin
            special_res_s = ALL_ZERO;
         end else begin
            special_res_s = MOST_NEG;
         end
      end
   end

   // One restoring step: shift in the next dividend bit and trial-subtract.
   // The shifted remainder carries a spare top bit so the borrow is visible.
   always_comb begin
      shifted_s  = {rem_r, quo_r[WIDTH-1]};
      diff_s     = shifted_s - {2'b00, dvsr_r};
      step_ok_s  = ~diff_s[WIDTH+1];
      rem_next_s = shifted_s[WIDTH:0];
      quo_next_s = {quo_r[WIDTH-2:0], 1'b0};
      if (step_ok_s) begin
         rem_next_s = diff_s[WIDTH:0];
         quo_next_s = {quo_r[WIDTH-2:0], 1'b1};
      end else begin
         rem_next_s = shifted_s[WIDTH:0];
         quo_next_s = {quo_r[WIDTH-2:0], 1'b0};
      end
   end

   // Sign fix-up of the unsigned quotient or remainder.
   always_comb begin
      fix_res_s = ALL_ZERO;
      if (is_rem_r) begin
         fix_res_s = apply_sign(rem_r[WIDTH-1:0], neg_rem_r);
      end else begin
         fix_res_s = apply_sign(quo_r, neg_quo_r);
      end
   end

   // Next-state and next-handshake decode; flush overrides everything.
   always_comb begin
      state_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (accept_s) begin
               if (special_s) begin
                  state_s = S_DONE;
               end else begin
                  state_s = S_DIVIDE;
               end
            end else begin
               state_s = S_IDLE;
            end
         end
         S_DIVIDE: begin
            if (cnt_r == CNT_ZERO) begin
               state_s = S_FIX;
            end else begin
               state_s = S_DIVIDE;
            end
         end
         S_FIX: begin
            state_s = S_DONE;
         end
         S_DONE: begin
            if (out_ready) begin
               state_s = S_IDLE;
            end else begin
               state_s = S_DONE;
            end
         end
         default: begin
            state_s = S_IDLE;
         end
      endcase
      if (flush) begin
         state_s = S_IDLE;
      end else begin
         state_s = state_s;
      end
      in_ready_s  = (state_s == S_IDLE);
      out_valid_s = (state_s == S_DONE);
   end

   // State register with registered handshake outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= S_IDLE;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
      end else begin
         state_r     <= state_s;
         in_ready_r  <= in_ready_s;
         out_valid_r <= out_valid_s;
      end
   end

   // Datapath: operand capture, iteration, fix-up and result hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         is_rem_r  <= 1'b0;
         neg_quo_r <= 1'b0;
         neg_rem_r <= 1'b0;
         dvsr_r    <= ALL_ZERO;
         quo_r     <= ALL_ZERO;
         rem_r     <= {(WIDTH+1){1'b0}};
         cnt_r     <= CNT_ZERO;
         result_r  <= ALL_ZERO;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (accept_s) begin
                  is_rem_r  <= op[1];
                  neg_quo_r <= is_signed_s & (a[WIDTH-1] ^ b[WIDTH-1]);
                  neg_rem_r <= is_signed_s & a[WIDTH-1];
                  if (special_s) begin
                     result_r <= special_res_s;
                  end else begin
                     dvsr_r <= magnitude(b, is_signed_s);
                     quo_r  <= magnitude(a, is_signed_s);
                     rem_r  <= {(WIDTH+1){1'b0}};
                     cnt_r  <= CNT_LAST;
                  end
               end
            end
            S_DIVIDE: begin
               rem_r <= rem_next_s;
               quo_r <= quo_next_s;
               if (cnt_r != CNT_ZERO) begin
                  cnt_r <= cnt_r - CNT_ONE;
               end
            end
            S_FIX: begin
               result_r <= fix_res_s;
            end
            S_DONE: begin
               result_r <= result_r;
            end
            default: begin
               result_r <= result_r;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_prv32_divider.sv
// Scoreboard bench for prv32_divider: a driver issues operations and queues
// the expected result and latency from an arithmetic reference model; an
// independent monitor pops and compares whenever a new result appears.
module tb_prv32_divider;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [1:0]  op = 2'd0;
   logic [31:0] a = 32'd0;
   logic [31:0] b = 32'd0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] result;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int rdy_mode = 0;   // 0 random, 1 held low, 2 held high

   typedef struct {
      logic [31:0] res;
      int          acc;
      int          lat;
   } exp_t;
   exp_t sb_q[$];

   prv32_divider #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: RV32M semantics using 64-bit integer arithmetic.
   function automatic logic [31:0] ref_res(input logic [1:0] o, input logic [31:0] x,
                                           input logic [31:0] y);
      longint sx, sy, ux, uy, r;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = longint'({32'd0, x});
      uy = longint'({32'd0, y});
      if (y == 32'd0) begin
         r = o[1] ? ux : -64'sd1;
      end else begin
         case (o)
            2'b00:   r = sx / sy;
            2'b01:   r = ux / uy;
            2'b10:   r = sx % sy;
            default: r = ux % uy;
         endcase
      end
      return r[31:0];
   endfunction

   function automatic int ref_lat(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      if (y == 32'd0 || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)) return 1;
      return 34;
   endfunction

   // Consumer: drives out_ready on the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         if (rdy_mode == 0) out_ready = ($urandom_range(0, 3) != 0);
         else out_ready = (rdy_mode == 2);
      end
   end

   // Monitor: pops and checks each new result; checks it is held while stalled.
   initial begin
      logic        prev_valid;
      logic [31:0] held;
      exp_t        e;
      prev_valid = 1'b0;
      held = 32'd0;
      forever begin
         @(negedge clk);
         if (rst_n && out_valid) begin
            if (!prev_valid) begin
               if (sb_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_valid: got result %h with no operation pending", result);
               end else begin
                  e = sb_q.pop_front();
                  chk("result", result, e.res);
                  chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
               end
               held = result;
            end else begin
               chk("result_hold", result, held);
               chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
            end
         end
         prev_valid = rst_n && out_valid;
      end
   end

   task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input bit track);
      int n;
      exp_t e;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         checks++;
         failures++;
         $display("FAIL issue_timeout: in_ready got %b expected 1", in_ready);
         return;
      end
      op = o;
      a = x;
      b = y;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      op = 2'($urandom);
      a = $urandom;
      b = $urandom;
      if (track) begin
         e.res = ref_res(o, x, y);
         e.acc = cyc;
         e.lat = ref_lat(o, x, y);
         sb_q.push_back(e);
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((sb_q.size() != 0 || out_valid) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("drain_pending", 32'(sb_q.size()), 32'd0);
      chk("drain_valid", {31'd0, out_valid}, 32'd0);
   endtask

   initial begin
      logic [31:0] ra, rb;
      logic [1:0]  ro;
      int n;

      // reset values
      #12;
      chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
      chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
      chk("reset_result", result, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // directed operations
      issue(2'b00, 32'hFFFF_FFF9, 32'd2, 1'b1);
      issue(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1);
      issue(2'b01, 32'hFFFF_FFFF, 32'h10, 1'b1);
      issue(2'b11, 32'hFFFF_FFFF, 32'h10, 1'b1);
      issue(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      issue(2'b00, 32'd5, 32'd0, 1'b1);
      issue(2'b11, 32'd5, 32'd0, 1'b1);
      issue(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      drain();

      // backpressure: out_ready low for 5 cycles with the result present
      @(posedge clk);
      #1;
      rdy_mode = 1;
      issue(2'b00, 32'd100, 32'd7, 1'b1);
      n = 0;
      while (!out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("bp_valid_seen", {31'd0, out_valid}, 32'd1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
         chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
         chk("bp_result", result, 32'd14);
      end
      @(posedge clk);
      #1;
      rdy_mode = 2;
      @(posedge clk);
      #1;
      chk("bp_after_valid", {31'd0, out_valid}, 32'd0);
      chk("bp_after_ready", {31'd0, in_ready}, 32'd1);
      rdy_mode = 0;

      // flush during iteration 10; no result may appear
      issue(2'b00, 32'd1000, 32'd3, 1'b0);
      repeat (10) @(posedge clk);
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
      chk("flush_out_valid", {31'd0, out_valid}, 32'd0);

      // flush together with in_valid in IDLE accepts nothing
      @(negedge clk);
      flush = 1'b1;
      in_valid = 1'b1;
      op = 2'b01;
      a = 32'd9;
      b = 32'd3;
      @(posedge clk);
      #1;
      flush = 1'b0;
      in_valid = 1'b0;
      chk("flush_prio_in_ready", {31'd0, in_ready}, 32'd1);
      repeat (40) @(negedge clk);
      issue(2'b01, 32'd9, 32'd3, 1'b1);
      drain();

      // asynchronous reset mid-divide
      issue(2'b00, 32'd12345, 32'd17, 1'b0);
      repeat (8) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);

      // randomized operations
      for (int i = 0; i < 80; i++) begin
         ro = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 5))
            0:       ra = 32'h8000_0000;
            1:       ra = 32'hFFFF_FFFF;
            2:       ra = 32'($urandom_range(0, 20));
            default: ra = $urandom;
         endcase
         case ($urandom_range(0, 6))
            0:       rb = 32'd0;
            1:       rb = 32'hFFFF_FFFF;
            2:       rb = 32'd1;
            3:       rb = 32'($urandom_range(1, 20));
            4:       rb = $urandom >> $urandom_range(0, 31);
            default: rb = $urandom;
         endcase
         issue(ro, ra, rb, 1'b1);
      end
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/prv32_divider.md
Name: prv32_divider

Overview:
- Sequential radix-2 divide unit for the RV32M DIV/DIVU/REM/REMU instructions. It replaces the single-cycle combinational divide path with a fixed-latency iterative engine.
- Sits beside the ALU in the execute stage. The pipeline holds the issuing instruction until the result handshake completes.
- Uses valid/ready handshakes on both the operand side and the result side.

Parameters:
- WIDTH, 32, operand and result width in bits. Normal-path latency is WIDTH+2 clocks.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous kill; aborts any operation in progress.
- in_valid  input  1  operands and op are valid.
- in_ready  output  1  unit can accept an operation; high only in IDLE.
- op  input  2  operation select: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- a  input  WIDTH  dividend.
- b  input  WIDTH  divisor.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  quotient or remainder, selected by op.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, counter=0, result=0, out_valid=0, so in_ready=1.
  - Reset takes effect immediately, including mid-operation; the in-flight operation is lost.
- Acceptance: an operation is accepted on a rising edge where in_valid & in_ready & ~flush. The unit captures op, a, b and the sign information at that edge. Inputs are ignored at all other times.
- States: IDLE -> DIVIDE -> FIX -> DONE -> IDLE; a special case goes IDLE -> DONE.
- IDLE, on acceptance:
  - If b==0: result is set to all-ones for DIV/DIVU, or to a for REM/REMU. Next state DONE.
  - Else if op==DIV and a==2^(WIDTH-1) and b==all-ones (signed overflow): result is 2^(WIDTH-1) for DIV, or 0 for REM. Next state DONE. The REM overflow check uses op==REM.
  - Else: load the magnitudes |a| and |b| (raw values for DIVU/REMU), clear the partial remainder, set counter=WIDTH-1, next state DIVIDE.
- DIVIDE: one restoring step per clock.
  - Shift {rem,quo} left by 1, bringing in the next dividend bit.
  - Trial-subtract the divisor magnitude; if the difference is non-negative, keep it and set the quotient LSB to 1.
  - After the step with counter==0, go to FIX. Otherwise decrement the counter.
- FIX, one clock:
  - DIV quotient sign = a[WIDTH-1]^b[WIDTH-1]; REM remainder sign = sign of a.
  - Negate via two's complement where the sign is 1. Load result, go to DONE.
- DONE:
  - out_valid=1 and result held stable until out_ready is high on an edge.
  - On that edge go to IDLE; out_valid is 0 and in_ready is 1 in the next cycle.
  - No back-to-back acceptance in the same edge as result consumption.
- Latency:
  - Normal path: out_valid first high in the cycle after the (WIDTH+2)th rising edge following the accepting edge, i.e. 34 edges for WIDTH=32.
  - Special cases: out_valid is high after 1 edge.
- Flush:
  - In any state, flush high on an edge forces IDLE and clears out_valid.
  - Flush has priority over acceptance (flush & in_valid in IDLE accepts nothing) and over out_ready.
  - result retains its last value after a flush; it is don't-care when out_valid=0.
- Width rules:
  - Partial remainder is WIDTH+1 bits, so the trial subtraction never overflows.
  - Magnitude of 2^(WIDTH-1) is handled as unsigned 2^(WIDTH-1).
  - No arithmetic exceptions are raised; there are no X values on result after reset.

Test Plan:
- DIV a=0xFFFFFFF9 (-7), b=2 -> result 0xFFFFFFFD, out_valid at edge 34. REM with the same operands -> 0xFFFFFFFF.
- DIVU a=0xFFFFFFFF, b=0x10 -> 0x0FFFFFFF. REMU with the same operands -> 0x0000000F. DIVU 0x80000000/0xFFFFFFFF -> 0 (no overflow special case).
- Divide by zero: DIV 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5, both with out_valid after 1 edge.
- Signed overflow: DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0; out_valid after 1 edge.
- Backpressure: DIV 100/7 completes with out_ready low for 5 cycles.
  - result stays 14 and out_valid stays 1 throughout; in_ready stays 0.
  - After the out_ready edge: out_valid=0 and in_ready=1.
- Flush and reset:
  - Flush in DIVIDE at iteration 10 -> out_valid never rises, in_ready=1 the next cycle.
  - A subsequent DIVU 9/3 -> 3.
  - rst_n pulsed low mid-DIVIDE -> in_ready=1, out_valid=0 immediately, without waiting for a clock edge.
